// File: rtl/decode_ctrl_pipe_if.sv
// ID-stage instruction in, registered ID/EX control bundle out.
// master drives the instruction side and hold/flush; slave is the decoder.
interface decode_ctrl_pipe_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        stall_in;
  logic        flush;
  logic        stall_out;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic        ex_alusrc;
  logic        ex_zext;
  logic        ex_shift;
  logic        ex_regwrite;
  logic [4:0]  ex_dest;
  logic        ex_readmem;
  logic        ex_writemem;
  logic        ex_memtoreg;
  logic [1:0]  ex_memsize;
  logic [1:0]  ex_branch;
  logic [1:0]  ex_jump;
  logic        ex_illegal;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_shamt;
  logic [15:0] ex_imm;

  modport master (
    output id_valid, id_instr, stall_in, flush,
    input  stall_out, ex_valid, ex_aluop, ex_alusrc, ex_zext, ex_shift, ex_regwrite,
           ex_dest, ex_readmem, ex_writemem, ex_memtoreg, ex_memsize, ex_branch,
           ex_jump, ex_illegal, ex_rs, ex_rt, ex_shamt, ex_imm
  );

  modport slave (
    input  id_valid, id_instr, stall_in, flush,
    output stall_out, ex_valid, ex_aluop, ex_alusrc, ex_zext, ex_shift, ex_regwrite,
           ex_dest, ex_readmem, ex_writemem, ex_memtoreg, ex_memsize, ex_branch,
           ex_jump, ex_illegal, ex_rs, ex_rt, ex_shamt, ex_imm
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// MIPS control decode into the ID/EX register (1-cycle latency) with load-use bubbles.
// stall_in freezes EX and the bubble FSM; flush kills ID and aborts pending bubbles.
module decode_ctrl_pipe #(
  parameter int unsigned LOAD_STALLS = 1,
  parameter bit          HAZARD_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  decode_ctrl_pipe_if.slave bus
);
  localparam logic [3:0] ALU_NOP  = 4'd0,  ALU_ADD = 4'd1,  ALU_ADDU = 4'd2,  ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SUBU = 4'd4,  ALU_AND = 4'd5,  ALU_OR   = 4'd6,  ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9, ALU_SLL  = 4'd10, ALU_SRL = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12, ALU_LUI = 4'd13;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        zext;
    logic        shift;
    logic        regwrite;
    logic [4:0]  dest;
    logic        readmem;
    logic        writemem;
    logic        memtoreg;
    logic [1:0]  memsize;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } ctrl_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = bus.id_instr[31:26];
  assign rs = bus.id_instr[25:21];
  assign rt = bus.id_instr[20:16];
  assign rd = bus.id_instr[15:11];
  assign fn = bus.id_instr[5:0];

  ctrl_t      dec;
  logic       wr;
  logic [4:0] dst;

  always_comb begin
    dec       = '0;
    wr        = 1'b0;
    dst       = '0;
    dec.valid = 1'b1;
    dec.rs    = rs;
    dec.rt    = rt;
    dec.shamt = bus.id_instr[10:6];
    dec.imm   = bus.id_instr[15:0];
    case (op)
      6'h00: begin
        wr  = 1'b1;
        dst = rd;
        case (fn)
          6'h20: dec.aluop = ALU_ADD;
          6'h21: dec.aluop = ALU_ADDU;
          6'h22: dec.aluop = ALU_SUB;
          6'h23: dec.aluop = ALU_SUBU;
          6'h24: dec.aluop = ALU_AND;
          6'h25: dec.aluop = ALU_OR;
          6'h27: dec.aluop = ALU_NOR;
          6'h2A: dec.aluop = ALU_SLT;
          6'h2B: dec.aluop = ALU_SLTU;
          6'h00: begin dec.aluop = ALU_SLL; dec.shift = 1'b1; end
          6'h02: begin dec.aluop = ALU_SRL; dec.shift = 1'b1; end
          6'h03: begin dec.aluop = ALU_SRA; dec.shift = 1'b1; end
          6'h08: begin dec.jump = 2'd2; wr = 1'b0; dst = '0; end
          default: begin dec.illegal = 1'b1; wr = 1'b0; dst = '0; end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
        dec.alusrc = 1'b1;
        wr         = 1'b1;
        dst        = rt;
        dec.zext   = (op == 6'h0C) || (op == 6'h0D);
        case (op)
          6'h08:   dec.aluop = ALU_ADD;
          6'h09:   dec.aluop = ALU_ADDU;
          6'h0A:   dec.aluop = ALU_SLT;
          6'h0B:   dec.aluop = ALU_SLTU;
          6'h0C:   dec.aluop = ALU_AND;
          6'h0D:   dec.aluop = ALU_OR;
          default: dec.aluop = ALU_LUI;
        endcase
      end
      6'h23, 6'h24, 6'h25: begin
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.readmem  = 1'b1;
        dec.memtoreg = 1'b1;
        wr           = 1'b1;
        dst          = rt;
        dec.memsize  = (op == 6'h23) ? 2'd2 : (op == 6'h24) ? 2'd0 : 2'd1;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.writemem = 1'b1;
        dec.memsize  = (op == 6'h28) ? 2'd0 : (op == 6'h29) ? 2'd1 : 2'd2;
      end
      6'h04, 6'h05: begin
        dec.aluop  = ALU_SUB;
        dec.branch = (op == 6'h04) ? 2'd1 : 2'd2;
      end
      6'h02:   dec.jump = 2'd1;
      default: dec.illegal = 1'b1;
    endcase
    dec.dest     = dst;
    dec.regwrite = wr && (dst != 5'd0);
  end

  ctrl_t      ex_q, ex_d;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       use_rs, use_rt, hazard, busy;

  assign use_rs = !((op == 6'h02) || (op == 6'h0F) ||
                    ((op == 6'h00) && ((fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03))));
  assign use_rt = ((op == 6'h00) && (fn != 6'h08)) || (op == 6'h04) || (op == 6'h05) ||
                  (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  assign hazard = HAZARD_EN && bus.id_valid && ex_q.valid && ex_q.readmem &&
                  (ex_q.dest != 5'd0) &&
                  ((use_rs && (rs == ex_q.dest)) || (use_rt && (rt == ex_q.dest)));
  assign busy   = (state_q == BUBBLE);

  // stall_out is gated by flush so a taken branch can redirect fetch immediately.
  assign bus.stall_out = !rst && !bus.flush && (busy || hazard);

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      ex_d    = '0;
      state_d = RUN;
      cnt_d   = '0;
    end else if (!bus.stall_in) begin
      if (busy) begin
        ex_d  = '0;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end else if (hazard) begin
        ex_d = '0;
        if (LOAD_STALLS > 1) begin
          state_d = BUBBLE;
          cnt_d   = 3'(LOAD_STALLS - 1);
        end
      end else begin
        ex_d = bus.id_valid ? dec : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_zext     = ex_q.zext;
  assign bus.ex_shift    = ex_q.shift;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_dest     = ex_q.dest;
  assign bus.ex_readmem  = ex_q.readmem;
  assign bus.ex_writemem = ex_q.writemem;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_memsize  = ex_q.memsize;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_jump     = ex_q.jump;
  assign bus.ex_illegal  = ex_q.illegal;
  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_shamt    = ex_q.shamt;
  assign bus.ex_imm      = ex_q.imm;
endmodule
